// File: rtl/seq46_pkg.sv
// Shared types and constants for the mod4/mod6 sandwich-counter lock checker.
// The state enum, segment encodings and saturating helpers are used by the model and top.
package seq46_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic       MOD4      = 1'b1;
    localparam logic       MOD6      = 1'b0;
    localparam logic [3:0] SEG4_LAST = 4'd3;
    localparam logic [3:0] SEG6_LAST = 4'd5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/seq46_model.sv
// Next-value predictor for the sandwich counter.
// Counts 0..3 in mod4, then 0..5 in mod6, then back to mod4.
module seq46_model
    import seq46_pkg::*;
(
    input  logic       phase,
    input  logic [3:0] expected,
    output logic       next_phase,
    output logic [3:0] next_expected
);

    // Advance within the segment, or wrap to 0 and swap segments at its last value.
    always_comb begin
        next_phase    = phase;
        next_expected = expected + 4'd1;
        if (phase == MOD4) begin
            if (expected == SEG4_LAST) begin
                next_phase    = MOD6;
                next_expected = 4'd0;
            end else begin
                next_phase    = MOD4;
            end
        end else begin
            if (expected == SEG6_LAST) begin
                next_phase    = MOD4;
                next_expected = 4'd0;
            end else begin
                next_phase    = MOD6;
            end
        end
    end

endmodule

// File: rtl/seq46_checker.sv
// Lock checker for the mod4/mod6 sandwich counter: hunts the 5->0 boundary,
// verifies LOCK_CNT matches, then flywheels while counting errors and super-frames.
module seq46_checker
    import seq46_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned MISS_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  in_cnt,
    input  logic        clr_stats,
    output logic        locked,
    output logic        err_pulse,
    output logic        sf_done,
    output logic        phase,
    output logic [3:0]  expected,
    output logic [15:0] sf_count,
    output logic [7:0]  err_count
);

    localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_MAX_W = 4'(MISS_MAX);

    state_t      state_r;
    logic [3:0]  prev_r;
    logic [3:0]  good_r;
    logic [3:0]  miss_r;
    logic        locked_r;
    logic        err_pulse_r;
    logic        sf_done_r;
    logic        phase_r;
    logic [3:0]  expected_r;
    logic [15:0] sf_count_r;
    logic [7:0]  err_count_r;

    logic        next_phase_s;
    logic [3:0]  next_expected_s;
    logic        match_s;
    logic        sf_hit_s;
    logic        err_hit_s;

    seq46_model u_model (
        .phase         (phase_r),
        .expected      (expected_r),
        .next_phase    (next_phase_s),
        .next_expected (next_expected_s)
    );

    // Values above 5 never occur in a healthy stream, so they never match.
    assign match_s   = (in_cnt == expected_r) && (in_cnt <= SEG6_LAST);
    assign sf_hit_s  = in_valid && (state_r == LOCKED) && match_s &&
                       (phase_r == MOD6) && (expected_r == SEG6_LAST);
    assign err_hit_s = in_valid && (state_r == LOCKED) && !match_s;

    // Lock FSM with registered status and prediction outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            prev_r      <= 4'd0;
            good_r      <= 4'd0;
            miss_r      <= 4'd0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            sf_done_r   <= 1'b0;
            phase_r     <= MOD4;
            expected_r  <= 4'd0;
        end else begin
            err_pulse_r <= 1'b0;
            sf_done_r   <= 1'b0;
            if (in_valid) begin
                prev_r <= in_cnt;
                case (state_r)
                    HUNT: begin
                        if ((in_cnt == 4'd0) && (prev_r == SEG6_LAST)) begin
                            phase_r    <= MOD4;
                            expected_r <= 4'd1;
                            good_r     <= 4'd1;
                            miss_r     <= 4'd0;
                            if (LOCK_CNT_W == 4'd1) begin
                                state_r  <= LOCKED;
                                locked_r <= 1'b1;
                            end else begin
                                state_r  <= VERIFY;
                            end
                        end else begin
                            state_r <= HUNT;
                        end
                    end
                    VERIFY: begin
                        if (match_s) begin
                            good_r     <= good_r + 4'd1;
                            phase_r    <= next_phase_s;
                            expected_r <= next_expected_s;
                            if ((good_r + 4'd1) == LOCK_CNT_W) begin
                                state_r  <= LOCKED;
                                locked_r <= 1'b1;
                                miss_r   <= 4'd0;
                            end else begin
                                state_r  <= VERIFY;
                            end
                        end else begin
                            state_r <= HUNT;
                            good_r  <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: keep predicting even through bad samples.
                        phase_r    <= next_phase_s;
                        expected_r <= next_expected_s;
                        if (match_s) begin
                            miss_r    <= 4'd0;
                            sf_done_r <= sf_hit_s;
                        end else begin
                            err_pulse_r <= 1'b1;
                            if ((miss_r + 4'd1) == MISS_MAX_W) begin
                                state_r  <= HUNT;
                                locked_r <= 1'b0;
                                miss_r   <= 4'd0;
                                good_r   <= 4'd0;
                            end else begin
                                miss_r   <= miss_r + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_r  <= HUNT;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Statistics counters; a clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sf_count_r  <= 16'd0;
            err_count_r <= 8'd0;
        end else if (clr_stats) begin
            sf_count_r  <= 16'd0;
            err_count_r <= 8'd0;
        end else begin
            if (sf_hit_s) begin
                sf_count_r <= sat_inc16(sf_count_r);
            end
            if (err_hit_s) begin
                err_count_r <= sat_inc8(err_count_r);
            end
        end
    end

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign sf_done   = sf_done_r;
    assign phase     = phase_r;
    assign expected  = expected_r;
    assign sf_count  = sf_count_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_seq46_checker.sv
// Self-checking bench for seq46_checker: vector table through a scoreboard queue,
// plus hand-built sequences for valid gaps and mid-frame reset.
module tb_seq46_checker;

    typedef struct {
        logic        v;
        logic [3:0]  c;
        logic        clr;
        logic        l;
        logic        e;
        logic        s;
        logic [7:0]  ec;
        logic [15:0] sc;
        logic        ckm;
        logic        ph;
        logic [3:0]  ex;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_cnt;
    logic        clr_stats;
    logic        locked;
    logic        err_pulse;
    logic        sf_done;
    logic        phase;
    logic [3:0]  expected;
    logic [15:0] sf_count;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int step  = 0;
    vec_t tbl[$];
    vec_t sb[$];

    seq46_checker #(.LOCK_CNT(4), .MISS_MAX(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_cnt    (in_cnt),
        .clr_stats (clr_stats),
        .locked    (locked),
        .err_pulse (err_pulse),
        .sf_done   (sf_done),
        .phase     (phase),
        .expected  (expected),
        .sf_count  (sf_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, step, act, exp);
        end
    endtask

    task automatic row(input logic v, input logic [3:0] c, input logic clr,
                       input logic l, input logic e, input logic s,
                       input logic [7:0] ec, input logic [15:0] sc);
        vec_t r;
        r.v = v; r.c = c; r.clr = clr; r.l = l; r.e = e; r.s = s;
        r.ec = ec; r.sc = sc; r.ckm = 1'b0; r.ph = 1'b0; r.ex = 4'd0;
        tbl.push_back(r);
    endtask

    task automatic mdl(input logic ph, input logic [3:0] ex);
        tbl[tbl.size()-1].ckm = 1'b1;
        tbl[tbl.size()-1].ph  = ph;
        tbl[tbl.size()-1].ex  = ex;
    endtask

    // Clean run of valid samples lo..hi with no pulses expected.
    task automatic run(input int lo, input int hi, input logic l,
                       input logic [7:0] ec, input logic [15:0] sc);
        for (int k = lo; k <= hi; k++) row(1'b1, 4'(k), 1'b0, l, 1'b0, 1'b0, ec, sc);
    endtask

    task automatic check_out();
        vec_t x;
        x = sb.pop_front();
        chk("locked",    32'(locked),    32'(x.l));
        chk("err_pulse", 32'(err_pulse), 32'(x.e));
        chk("sf_done",   32'(sf_done),   32'(x.s));
        chk("err_count", 32'(err_count), 32'(x.ec));
        chk("sf_count",  32'(sf_count),  32'(x.sc));
        if (x.ckm) begin
            chk("phase",    32'(phase),    32'(x.ph));
            chk("expected", 32'(expected), 32'(x.ex));
        end
    endtask

    task automatic apply(input vec_t r);
        in_valid  = r.v;
        in_cnt    = r.c;
        clr_stats = r.clr;
        sb.push_back(r);
        @(posedge clk);
        #1;
        step++;
        check_out();
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_locked"},    32'(locked),    32'd0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "_sf_done"},   32'(sf_done),   32'd0);
        chk({tag, "_phase"},     32'(phase),     32'd1);
        chk({tag, "_expected"},  32'(expected),  32'd0);
        chk({tag, "_sf_count"},  32'(sf_count),  32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        vec_t r;
        int   vi;
        int   sc_e;
        rst_n = 1'b0; in_valid = 1'b0; in_cnt = 4'd0; clr_stats = 1'b0;

        // VERIFY aborted by a mismatch on its 2nd sample.
        row(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
        row(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0); mdl(1'b1, 4'd1);
        row(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
        // Clean acquisition: lock on the 3 that completes four matches.
        run(4, 5, 1'b0, 8'd0, 16'd0);
        row(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
        run(1, 2, 1'b0, 8'd0, 16'd0);
        row(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0); mdl(1'b0, 4'd0);
        run(0, 4, 1'b1, 8'd0, 16'd0);
        row(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 16'd1); mdl(1'b1, 4'd0);
        // Single corrupted sample (2 -> 7) while locked.
        run(0, 1, 1'b1, 8'd0, 16'd1);
        row(1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 16'd1); mdl(1'b1, 4'd3);
        row(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'd1);
        run(0, 4, 1'b1, 8'd1, 16'd1);
        row(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 16'd2);
        // Invalid cycles hold everything.
        row(1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'd2); mdl(1'b1, 4'd0);
        row(1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'd2);
        // clr_stats coinciding with a matched 5 in mod6.
        run(0, 3, 1'b1, 8'd1, 16'd2);
        run(0, 4, 1'b1, 8'd1, 16'd2);
        row(1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 16'd0);
        // Three consecutive misses drop lock, then relock.
        run(0, 1, 1'b1, 8'd0, 16'd0);
        row(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 16'd0);
        row(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 16'd0);
        row(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 16'd0);
        run(4, 5, 1'b0, 8'd3, 16'd0);
        row(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 16'd0);
        run(1, 2, 1'b0, 8'd3, 16'd0);
        row(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 16'd0); mdl(1'b0, 4'd0);
        run(0, 4, 1'b1, 8'd3, 16'd0);
        row(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 16'd1);
        // Clear on an idle cycle.
        row(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0);

        repeat (2) @(posedge clk);
        #1;
        reset_values("rst");
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Valid toggling 1010 over a clean stream: one super-frame per 10 valid samples.
        vi = 0;
        sc_e = 0;
        for (int k = 0; k < 40; k++) begin
            r = '{default: '0};
            r.l = 1'b1;
            if (k % 2 == 0) begin
                r.v = 1'b1;
                r.c = 4'(((vi % 10) < 4) ? (vi % 10) : (vi % 10) - 4);
                if ((vi % 10) == 9) begin
                    sc_e++;
                    r.s = 1'b1;
                end
                vi++;
            end else begin
                r.c = 4'd7;
            end
            r.sc = 16'(sc_e);
            apply(r);
        end

        // Mid-frame asynchronous reset, then re-hunt without counting a partial frame.
        for (int k = 0; k < 3; k++) begin
            r = '{default: '0};
            r.v = 1'b1; r.c = 4'(k); r.l = 1'b1; r.sc = 16'd2;
            apply(r);
        end
        #2;
        rst_n = 1'b0;
        #1;
        reset_values("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            r = '{default: '0};
            r.v = 1'b1; r.c = 4'(k);
            apply(r);
        end
        r = '{default: '0};
        r.v = 1'b1; r.c = 4'd0; r.ckm = 1'b1; r.ph = 1'b1; r.ex = 4'd1;
        apply(r);
        for (int k = 1; k <= 3; k++) begin
            r = '{default: '0};
            r.v = 1'b1; r.c = 4'(k); r.l = (k == 3);
            apply(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
